fp_add_operand_unpack: RTL

//  Front end of the dual-mode FP adder, feeding Result_and_exception.
//  - Accepts two operands, each either two packed narrow lanes (i_mode=0) or one wide value (i_mode=1).
//  - Classifies each operand, swaps so the larger magnitude is first, and computes the effective op.
//  - Aligns the smaller fraction and produces the e_* class flags the back end consumes.
//  - 2-stage valid/ready pipeline.

---
 rtl/fp_add_operand_unpack.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/fp_add_operand_unpack.sv
// rtl/fp_add_operand_unpack.sv - dual-mode FP adder front end: unpack, swap, classify and align operands
`timescale 1ns/1ps
module fp_add_operand_unpack #(
    parameter int FRAC_W       = 52,
    parameter int EXP_W        = 16,
    parameter int LANE0_FRAC_W = 23,
    parameter int DBL_EXP_W    = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic              i_mode,
    input  logic [1:0]        i_op,
    input  logic [1:0]        i_sign_a,
    input  logic [1:0]        i_sign_b,
    input  logic [EXP_W-1:0]  i_exp_a,
    input  logic [EXP_W-1:0]  i_exp_b,
    input  logic [FRAC_W-1:0] i_frac_a,
    input  logic [FRAC_W-1:0] i_frac_b,
    output logic              o_valid,
    input  logic              o_ready,
    output logic              o_mode,
    output logic [1:0]        e_op,
    output logic [1:0]        o_sign,
    output logic [1:0]        e_large_expff,
    output logic [1:0]        e_large_frac00,
    output logic [1:0]        e_small_expff,
    output logic [1:0]        e_small_frac00,
    output logic [EXP_W-1:0]  o_exp,
    output logic [FRAC_W+1:0] o_large_frac,
    output logic [FRAC_W+1:0] o_small_frac,
    output logic [1:0]        o_sticky
);
    localparam int LW = EXP_W / 2;
    localparam int F0 = LANE0_FRAC_W;
    localparam int F1 = FRAC_W - LANE0_FRAC_W;
    localparam int DE = DBL_EXP_W;
    localparam int SW = FRAC_W + 2;

    logic              s1_valid, s2_valid, s1_ready, s2_ready;
    logic              s1_mode;
    logic [1:0]        s1_op, s1_sign_a, s1_sign_b;
    logic [EXP_W-1:0]  s1_exp_a, s1_exp_b;
    logic [FRAC_W-1:0] s1_frac_a, s1_frac_b;

    assign s2_ready = ~s2_valid | o_ready;
    assign s1_ready = ~s1_valid | s2_ready;
    assign i_ready  = s1_ready;
    assign o_valid  = s2_valid;

    // lane 0 (narrow, low half)
    logic [LW-1:0] l0_ea, l0_eb, l0_el, l0_es, l0_d;
    logic [F0-1:0] l0_fa, l0_fb, l0_fl, l0_fs;
    logic [F0:0]   l0_sig_l, l0_sig_s, l0_sh;
    logic          l0_a_lg, l0_st;
    assign l0_ea    = s1_exp_a[LW-1:0];
    assign l0_eb    = s1_exp_b[LW-1:0];
    assign l0_fa    = s1_frac_a[F0-1:0];
    assign l0_fb    = s1_frac_b[F0-1:0];
    assign l0_a_lg  = {l0_ea, l0_fa} >= {l0_eb, l0_fb};
    assign l0_el    = l0_a_lg ? l0_ea : l0_eb;
    assign l0_es    = l0_a_lg ? l0_eb : l0_ea;
    assign l0_fl    = l0_a_lg ? l0_fa : l0_fb;
    assign l0_fs    = l0_a_lg ? l0_fb : l0_fa;
    assign l0_sig_l = {|l0_el, l0_fl};
    assign l0_sig_s = {|l0_es, l0_fs};
    assign l0_d     = ((l0_el == '0) ? LW'(1) : l0_el) - ((l0_es == '0) ? LW'(1) : l0_es);
    assign l0_sh    = l0_sig_s >> l0_d;
    // Oversized shifts leave an all-ones mask, so sticky collapses to |sig
    assign l0_st    = |(l0_sig_s & ~({(F0+1){1'b1}} << l0_d));

    // lane 1 (narrow, high half)
    logic [LW-1:0] l1_ea, l1_eb, l1_el, l1_es, l1_d;
    logic [F1-1:0] l1_fa, l1_fb, l1_fl, l1_fs;
    logic [F1:0]   l1_sig_l, l1_sig_s, l1_sh;
    logic          l1_a_lg, l1_st;
    assign l1_ea    = s1_exp_a[EXP_W-1:LW];
    assign l1_eb    = s1_exp_b[EXP_W-1:LW];
    assign l1_fa    = s1_frac_a[FRAC_W-1:F0];
    assign l1_fb    = s1_frac_b[FRAC_W-1:F0];
    assign l1_a_lg  = {l1_ea, l1_fa} >= {l1_eb, l1_fb};
    assign l1_el    = l1_a_lg ? l1_ea : l1_eb;
    assign l1_es    = l1_a_lg ? l1_eb : l1_ea;
    assign l1_fl    = l1_a_lg ? l1_fa : l1_fb;
    assign l1_fs    = l1_a_lg ? l1_fb : l1_fa;
    assign l1_sig_l = {|l1_el, l1_fl};
    assign l1_sig_s = {|l1_es, l1_fs};
    assign l1_d     = ((l1_el == '0) ? LW'(1) : l1_el) - ((l1_es == '0) ? LW'(1) : l1_es);
    assign l1_sh    = l1_sig_s >> l1_d;
    assign l1_st    = |(l1_sig_s & ~({(F1+1){1'b1}} << l1_d));

    // wide lane
    logic [DE-1:0]     w_ea, w_eb, w_el, w_es, w_d;
    logic [FRAC_W-1:0] w_fl, w_fs;
    logic [FRAC_W:0]   w_sig_l, w_sig_s, w_sh;
    logic              w_a_lg, w_st;
    assign w_ea    = s1_exp_a[DE-1:0];
    assign w_eb    = s1_exp_b[DE-1:0];
    assign w_a_lg  = {w_ea, s1_frac_a} >= {w_eb, s1_frac_b};
    assign w_el    = w_a_lg ? w_ea : w_eb;
    assign w_es    = w_a_lg ? w_eb : w_ea;
    assign w_fl    = w_a_lg ? s1_frac_a : s1_frac_b;
    assign w_fs    = w_a_lg ? s1_frac_b : s1_frac_a;
    assign w_sig_l = {|w_el, w_fl};
    assign w_sig_s = {|w_es, w_fs};
    assign w_d     = ((w_el == '0) ? DE'(1) : w_el) - ((w_es == '0) ? DE'(1) : w_es);
    assign w_sh    = w_sig_s >> w_d;
    assign w_st    = |(w_sig_s & ~({(FRAC_W+1){1'b1}} << w_d));

    logic [1:0]       n_e_op, n_sign, n_lexpff, n_lfrac00, n_sexpff, n_sfrac00, n_sticky;
    logic [EXP_W-1:0] n_exp;
    logic [SW-1:0]    n_lfrac, n_sfrac;
    logic             w_eop, w_sign;

    assign w_eop  = s1_op[0] ^ s1_sign_a[0] ^ s1_sign_b[0];
    assign w_sign = w_a_lg ? s1_sign_a[0] : s1_sign_b[0];

    always_comb begin
        n_e_op    = {s1_op[1] ^ s1_sign_a[1] ^ s1_sign_b[1], w_eop};
        n_sign    = {l1_a_lg ? s1_sign_a[1] : s1_sign_b[1], l0_a_lg ? s1_sign_a[0] : s1_sign_b[0]};
        n_lexpff  = {&l1_el, &l0_el};
        n_lfrac00 = {~|l1_fl, ~|l0_fl};
        n_sexpff  = {&l1_es, &l0_es};
        n_sfrac00 = {~|l1_fs, ~|l0_fs};
        n_sticky  = {l1_st, l0_st};
        n_exp     = {l1_el, l0_el};
        n_lfrac   = {l1_sig_l, l0_sig_l};
        n_sfrac   = {l1_sh, l0_sh};
        if (s1_mode) begin
            n_e_op    = {2{w_eop}};
            n_sign    = {2{w_sign}};
            n_lexpff  = {2{&w_el}};
            n_lfrac00 = {2{~|w_fl}};
            n_sexpff  = {2{&w_es}};
            n_sfrac00 = {2{~|w_fs}};
            n_sticky  = {2{w_st}};
            n_exp     = {{(EXP_W-DE){1'b0}}, w_el};
            n_lfrac   = {1'b0, w_sig_l};
            n_sfrac   = {1'b0, w_sh};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_mode   <= 1'b0;
            s1_op     <= '0;
            s1_sign_a <= '0;
            s1_sign_b <= '0;
            s1_exp_a  <= '0;
            s1_exp_b  <= '0;
            s1_frac_a <= '0;
            s1_frac_b <= '0;
        end else if (s1_ready) begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_mode   <= i_mode;
                s1_op     <= i_op;
                s1_sign_a <= i_sign_a;
                s1_sign_b <= i_sign_b;
                s1_exp_a  <= i_exp_a;
                s1_exp_b  <= i_exp_b;
                s1_frac_a <= i_frac_a;
                s1_frac_b <= i_frac_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid       <= 1'b0;
            o_mode         <= 1'b0;
            e_op           <= '0;
            o_sign         <= '0;
            e_large_expff  <= '0;
            e_large_frac00 <= '0;
            e_small_expff  <= '0;
            e_small_frac00 <= '0;
            o_exp          <= '0;
            o_large_frac   <= '0;
            o_small_frac   <= '0;
            o_sticky       <= '0;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                o_mode         <= s1_mode;
                e_op           <= n_e_op;
                o_sign         <= n_sign;
                e_large_expff  <= n_lexpff;
                e_large_frac00 <= n_lfrac00;
                e_small_expff  <= n_sexpff;
                e_small_frac00 <= n_sfrac00;
                o_exp          <= n_exp;
                o_large_frac   <= n_lfrac;
                o_small_frac   <= n_sfrac;
                o_sticky       <= n_sticky;
            end
        end
    end
endmodule
